// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - speculative rename map table with 4-wide rename and streamed recovery
`timescale 1ns/1ps

module rename_map_table #(
    parameter int NUM_LOG = 32,
    parameter int LOG_W   = 5,
    parameter int PHYS_W  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      recoverFlag_i,
    input  logic [LOG_W+PHYS_W-1:0]   recoverPacket0_i,
    input  logic [LOG_W+PHYS_W-1:0]   recoverPacket1_i,
    input  logic [LOG_W+PHYS_W-1:0]   recoverPacket2_i,
    input  logic [LOG_W+PHYS_W-1:0]   recoverPacket3_i,
    input  logic                      renameValid_i,
    input  logic [8*LOG_W-1:0]        srcLog_i,
    input  logic [3:0]                destValid_i,
    input  logic [4*LOG_W-1:0]        destLog_i,
    input  logic [4*PHYS_W-1:0]       destPhys_i,
    output logic [8*PHYS_W-1:0]       srcPhys_o,
    output logic [4*PHYS_W-1:0]       oldDestPhys_o,
    output logic                      busy_o,
    output logic                      recoverDone_o,
    output logic                      recoverErr_o
);

    localparam int PKT_W = LOG_W + PHYS_W;

    typedef enum logic {IDLE, RECOVER} state_t;

    state_t              state;
    logic [LOG_W-1:0]    cnt;
    logic [PHYS_W-1:0]   mapTable [NUM_LOG];

    logic [PKT_W-1:0]    packet   [4];
    logic [LOG_W-1:0]    pktLog   [4];
    logic [PHYS_W-1:0]   pktPhys  [4];
    logic [LOG_W-1:0]    srcLog   [8];
    logic [LOG_W-1:0]    destLog  [4];
    logic [PHYS_W-1:0]   destPhys [4];
    logic [PHYS_W-1:0]   srcVal   [8];
    logic [PHYS_W-1:0]   oldVal   [4];
    logic [3:0]          laneWrite;

    logic                recoveryBeat;
    logic [LOG_W-1:0]    beatBase;
    logic                beatErr;
    logic                lastBeat;

    assign packet[0] = recoverPacket0_i;
    assign packet[1] = recoverPacket1_i;
    assign packet[2] = recoverPacket2_i;
    assign packet[3] = recoverPacket3_i;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            pktLog[p]   = packet[p][PKT_W-1:PHYS_W];
            pktPhys[p]  = packet[p][PHYS_W-1:0];
            destLog[p]  = destLog_i[p*LOG_W +: LOG_W];
            destPhys[p] = destPhys_i[p*PHYS_W +: PHYS_W];
        end
        for (int s = 0; s < 8; s++) begin
            srcLog[s] = srcLog_i[s*LOG_W +: LOG_W];
        end
    end

    // Ascending scan over older lanes leaves the youngest matching lane's tag in place.
    always_comb begin
        for (int s = 0; s < 8; s++) begin
            srcVal[s] = mapTable[srcLog[s]];
            for (int j = 0; j < 4; j++) begin
                if (j < s / 2 && destValid_i[j] && destLog[j] == srcLog[s]) begin
                    srcVal[s] = destPhys[j];
                end
            end
            srcPhys_o[s*PHYS_W +: PHYS_W] = srcVal[s];
        end
        for (int k = 0; k < 4; k++) begin
            oldVal[k] = mapTable[destLog[k]];
            for (int j = 0; j < 4; j++) begin
                if (j < k && destValid_i[j] && destLog[j] == destLog[k]) begin
                    oldVal[k] = destPhys[j];
                end
            end
            oldDestPhys_o[k*PHYS_W +: PHYS_W] = oldVal[k];
        end
    end

    // A lane writes only if no younger lane in the group targets the same register.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            laneWrite[k] = renameValid_i && !busy_o && destValid_i[k];
            for (int m = 0; m < 4; m++) begin
                if (m > k && destValid_i[m] && destLog[m] == destLog[k]) begin
                    laneWrite[k] = 1'b0;
                end
            end
        end
    end

    assign recoveryBeat = recoverFlag_i || (state == RECOVER);
    assign busy_o       = recoveryBeat;
    assign beatBase     = recoverFlag_i ? '0 : cnt;
    assign lastBeat     = (beatBase == LOG_W'(NUM_LOG - 4));

    always_comb begin
        beatErr = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (pktLog[p] != beatBase + LOG_W'(p)) begin
                beatErr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG; i++) begin
                mapTable[i] <= PHYS_W'(i);
            end
        end else if (recoveryBeat) begin
            for (int p = 0; p < 4; p++) begin
                mapTable[pktLog[p]] <= pktPhys[p];
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (laneWrite[k]) begin
                    mapTable[destLog[k]] <= destPhys[k];
                end
            end
        end
    end

    // A flag seen in RECOVER restarts the stream from beat 0 via beatBase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            recoverDone_o <= 1'b0;
            recoverErr_o  <= 1'b0;
        end else begin
            recoverDone_o <= 1'b0;
            if (recoveryBeat) begin
                if (beatErr) begin
                    recoverErr_o <= 1'b1;
                end
                if (lastBeat) begin
                    state         <= IDLE;
                    cnt           <= '0;
                    recoverDone_o <= 1'b1;
                end else begin
                    state <= RECOVER;
                    cnt   <= beatBase + LOG_W'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// tb/tb_rename_map_table.sv - self-checking bench for rename_map_table
`timescale 1ns/1ps

module tb_rename_map_table;

    localparam int NUM_LOG = 32;
    localparam int LOG_W   = 5;
    localparam int PHYS_W  = 7;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    recoverFlag_i;
    logic [LOG_W+PHYS_W-1:0] recoverPacket0_i;
    logic [LOG_W+PHYS_W-1:0] recoverPacket1_i;
    logic [LOG_W+PHYS_W-1:0] recoverPacket2_i;
    logic [LOG_W+PHYS_W-1:0] recoverPacket3_i;
    logic                    renameValid_i;
    logic [8*LOG_W-1:0]      srcLog_i;
    logic [3:0]              destValid_i;
    logic [4*LOG_W-1:0]      destLog_i;
    logic [4*PHYS_W-1:0]     destPhys_i;
    logic [8*PHYS_W-1:0]     srcPhys_o;
    logic [4*PHYS_W-1:0]     oldDestPhys_o;
    logic                    busy_o;
    logic                    recoverDone_o;
    logic                    recoverErr_o;

    always #5 clk = ~clk;

    rename_map_table #(.NUM_LOG(NUM_LOG), .LOG_W(LOG_W), .PHYS_W(PHYS_W)) dut (
        .clk(clk),
        .reset(reset),
        .recoverFlag_i(recoverFlag_i),
        .recoverPacket0_i(recoverPacket0_i),
        .recoverPacket1_i(recoverPacket1_i),
        .recoverPacket2_i(recoverPacket2_i),
        .recoverPacket3_i(recoverPacket3_i),
        .renameValid_i(renameValid_i),
        .srcLog_i(srcLog_i),
        .destValid_i(destValid_i),
        .destLog_i(destLog_i),
        .destPhys_i(destPhys_i),
        .srcPhys_o(srcPhys_o),
        .oldDestPhys_o(oldDestPhys_o),
        .busy_o(busy_o),
        .recoverDone_o(recoverDone_o),
        .recoverErr_o(recoverErr_o)
    );

    int asserts  = 0;
    int failures = 0;

    int                refTable [NUM_LOG];
    logic [LOG_W-1:0]  sl [8];
    logic [LOG_W-1:0]  dl [4];
    logic [PHYS_W-1:0] dp [4];
    logic [3:0]        dv;
    logic              rv;
    logic              flag;
    logic [LOG_W-1:0]  pl [4];
    logic [PHYS_W-1:0] pp [4];

    task automatic drive();
        for (int i = 0; i < 8; i++) srcLog_i[i*LOG_W +: LOG_W] = sl[i];
        for (int i = 0; i < 4; i++) begin
            destLog_i[i*LOG_W +: LOG_W]    = dl[i];
            destPhys_i[i*PHYS_W +: PHYS_W] = dp[i];
        end
        destValid_i      = dv;
        renameValid_i    = rv;
        recoverFlag_i    = flag;
        recoverPacket0_i = {pl[0], pp[0]};
        recoverPacket1_i = {pl[1], pp[1]};
        recoverPacket2_i = {pl[2], pp[2]};
        recoverPacket3_i = {pl[3], pp[3]};
    endtask

    task automatic quiet();
        rv = 1'b0;
        dv = 4'b0;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) sl[i] = LOG_W'(i);
        for (int i = 0; i < 4; i++) begin
            dl[i] = '0; dp[i] = '0; pl[i] = '0; pp[i] = '0;
        end
    endtask

    // Reference view of a group: the nearest older lane naming the register supplies the tag.
    function automatic int expSrc(int s);
        for (int j = s / 2 - 1; j >= 0; j--) begin
            if (dv[j] && dl[j] == sl[s]) return int'(dp[j]);
        end
        return refTable[sl[s]];
    endfunction

    function automatic int expOld(int k);
        for (int j = k - 1; j >= 0; j--) begin
            if (dv[j] && dl[j] == dl[k]) return int'(dp[j]);
        end
        return refTable[dl[k]];
    endfunction

    task automatic commitGroup();
        if (rv) begin
            for (int k = 0; k < 4; k++) begin
                if (dv[k]) refTable[dl[k]] = int'(dp[k]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet();
        for (int i = 0; i < 4; i++) dl[i] = LOG_W'(8 + i);
        drive();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NUM_LOG; i++) refTable[i] = i;
        #1;
        for (int s = 0; s < 8; s++) begin
            asserts++;
            if (srcPhys_o[s*PHYS_W +: PHYS_W] !== PHYS_W'(s)) begin
                failures++;
                $display("FAIL reset_src%0d: got %0d expected %0d", s, srcPhys_o[s*PHYS_W +: PHYS_W], s);
            end
        end
        for (int k = 0; k < 4; k++) begin
            asserts++;
            if (oldDestPhys_o[k*PHYS_W +: PHYS_W] !== PHYS_W'(8 + k)) begin
                failures++;
                $display("FAIL reset_old%0d: got %0d expected %0d", k, oldDestPhys_o[k*PHYS_W +: PHYS_W], 8 + k);
            end
        end
        asserts++;
        if ({busy_o, recoverDone_o, recoverErr_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got busy/done/err %b expected 000", {busy_o, recoverDone_o, recoverErr_o});
        end
        step();
    endtask

    task automatic test_bypass();
        quiet();
        rv = 1'b1; dv = 4'b0001; dl[0] = 5'd3; dp[0] = 7'd40;
        sl[4] = 5'd3;
        drive();
        #1;
        asserts++;
        if (srcPhys_o[4*PHYS_W +: PHYS_W] !== 7'd40) begin
            failures++;
            $display("FAIL bypass_src: got %0d expected 40", srcPhys_o[4*PHYS_W +: PHYS_W]);
        end
        asserts++;
        if (oldDestPhys_o[0 +: PHYS_W] !== 7'd3) begin
            failures++;
            $display("FAIL bypass_old: got %0d expected 3", oldDestPhys_o[0 +: PHYS_W]);
        end
        commitGroup();
        step();
        quiet();
        sl[0] = 5'd3;
        drive();
        #1;
        asserts++;
        if (srcPhys_o[0 +: PHYS_W] !== 7'd40) begin
            failures++;
            $display("FAIL bypass_next: got %0d expected 40", srcPhys_o[0 +: PHYS_W]);
        end
        step();
    endtask

    task automatic test_collision();
        quiet();
        rv = 1'b1; dv = 4'b1010;
        dl[1] = 5'd5; dp[1] = 7'd50;
        dl[3] = 5'd5; dp[3] = 7'd51;
        drive();
        #1;
        asserts++;
        if (oldDestPhys_o[3*PHYS_W +: PHYS_W] !== 7'd50) begin
            failures++;
            $display("FAIL collide_old3: got %0d expected 50", oldDestPhys_o[3*PHYS_W +: PHYS_W]);
        end
        asserts++;
        if (oldDestPhys_o[1*PHYS_W +: PHYS_W] !== 7'd5) begin
            failures++;
            $display("FAIL collide_old1: got %0d expected 5", oldDestPhys_o[1*PHYS_W +: PHYS_W]);
        end
        commitGroup();
        step();
        quiet();
        sl[0] = 5'd5;
        drive();
        #1;
        asserts++;
        if (srcPhys_o[0 +: PHYS_W] !== 7'd51) begin
            failures++;
            $display("FAIL collide_next: got %0d expected 51", srcPhys_o[0 +: PHYS_W]);
        end
        step();
    endtask

    task automatic test_random_rename();
        int e;
        for (int c = 0; c < 300; c++) begin
            quiet();
            rv = ($urandom_range(0, 3) != 0);
            dv = 4'($urandom);
            for (int i = 0; i < 8; i++)
                sl[i] = (c % 2 == 0) ? LOG_W'($urandom_range(0, 7)) : LOG_W'($urandom);
            for (int i = 0; i < 4; i++) begin
                dl[i] = (c % 2 == 0) ? LOG_W'($urandom_range(0, 7)) : LOG_W'($urandom);
                dp[i] = PHYS_W'($urandom);
            end
            drive();
            #1;
            for (int s = 0; s < 8; s++) begin
                e = expSrc(s);
                asserts++;
                if (srcPhys_o[s*PHYS_W +: PHYS_W] !== PHYS_W'(e)) begin
                    failures++;
                    $display("FAIL rand_src%0d cyc %0d: got %0d expected %0d", s, c, srcPhys_o[s*PHYS_W +: PHYS_W], e);
                end
            end
            for (int k = 0; k < 4; k++) begin
                e = expOld(k);
                asserts++;
                if (oldDestPhys_o[k*PHYS_W +: PHYS_W] !== PHYS_W'(e)) begin
                    failures++;
                    $display("FAIL rand_old%0d cyc %0d: got %0d expected %0d", k, c, oldDestPhys_o[k*PHYS_W +: PHYS_W], e);
                end
            end
            commitGroup();
            step();
        end
    endtask

    task automatic test_readback();
        int e;
        for (int c = 0; c < NUM_LOG / 8; c++) begin
            quiet();
            for (int s = 0; s < 8; s++) sl[s] = LOG_W'(c * 8 + s);
            drive();
            #1;
            for (int s = 0; s < 8; s++) begin
                e = refTable[c * 8 + s];
                asserts++;
                if (srcPhys_o[s*PHYS_W +: PHYS_W] !== PHYS_W'(e)) begin
                    failures++;
                    $display("FAIL readback_r%0d: got %0d expected %0d", c * 8 + s, srcPhys_o[s*PHYS_W +: PHYS_W], e);
                end
            end
            step();
        end
    endtask

    task automatic test_recovery();
        for (int b = 0; b < 8; b++) begin
            quiet();
            flag = (b == 0);
            for (int p = 0; p < 4; p++) begin
                pl[p] = LOG_W'(4 * b + p);
                pp[p] = PHYS_W'(100 - (4 * b + p));
            end
            if (b == 3) begin
                rv = 1'b1; dv = 4'hF;
                for (int k = 0; k < 4; k++) begin
                    dl[k] = LOG_W'(k); dp[k] = PHYS_W'(k + 1);
                end
            end
            drive();
            #1;
            asserts++;
            if (busy_o !== 1'b1 || recoverDone_o !== 1'b0) begin
                failures++;
                $display("FAIL recov_busy T+%0d: got busy %b done %b expected 1 0", b, busy_o, recoverDone_o);
            end
            step();
        end
        quiet();
        drive();
        #1;
        asserts++;
        if ({busy_o, recoverDone_o, recoverErr_o} !== 3'b010) begin
            failures++;
            $display("FAIL recov_done T+8: got busy/done/err %b expected 010", {busy_o, recoverDone_o, recoverErr_o});
        end
        for (int i = 0; i < NUM_LOG; i++) refTable[i] = 100 - i;
        step();
        asserts++;
        if (recoverDone_o !== 1'b0) begin
            failures++;
            $display("FAIL recov_pulse T+9: got %b expected 0", recoverDone_o);
        end
    endtask

    task automatic test_restart();
        for (int b = 0; b < 12; b++) begin
            quiet();
            flag = (b == 0 || b == 4);
            for (int p = 0; p < 4; p++) begin
                if (b < 4) begin
                    pl[p] = LOG_W'(4 * b + p);
                    pp[p] = PHYS_W'(3 * (4 * b + p) + 1);
                end else begin
                    pl[p] = LOG_W'(4 * (b - 4) + p);
                    pp[p] = PHYS_W'(120 - (4 * (b - 4) + p));
                end
            end
            drive();
            #1;
            asserts++;
            if (busy_o !== 1'b1 || recoverDone_o !== 1'b0) begin
                failures++;
                $display("FAIL restart_busy T+%0d: got busy %b done %b expected 1 0", b, busy_o, recoverDone_o);
            end
            step();
        end
        quiet();
        drive();
        #1;
        asserts++;
        if ({busy_o, recoverDone_o} !== 2'b01) begin
            failures++;
            $display("FAIL restart_done T+12: got busy/done %b expected 01", {busy_o, recoverDone_o});
        end
        for (int i = 0; i < NUM_LOG; i++) refTable[i] = 120 - i;
        step();
    endtask

    task automatic test_error();
        for (int b = 0; b < 10; b++) begin
            quiet();
            if (b < 8) begin
                flag = (b == 0);
                for (int p = 0; p < 4; p++) begin
                    pl[p] = LOG_W'(4 * b + p);
                    pp[p] = PHYS_W'(60 + 4 * b + p);
                end
                if (b == 2) pl[0] = 5'd9;
            end
            drive();
            #1;
            asserts++;
            if (recoverErr_o !== (b >= 3)) begin
                failures++;
                $display("FAIL err_sticky T+%0d: got %b expected %b", b, recoverErr_o, (b >= 3));
            end
            if (b == 8) begin
                asserts++;
                if (recoverDone_o !== 1'b1) begin
                    failures++;
                    $display("FAIL err_done T+8: got %b expected 1", recoverDone_o);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 6; b++) begin
            quiet();
            flag = (b == 0);
            for (int p = 0; p < 4; p++) begin
                pl[p] = LOG_W'(4 * b + p);
                pp[p] = PHYS_W'(90 - (4 * b + p));
            end
            reset = (b == 5);
            drive();
            step();
        end
        reset = 1'b0;
        quiet();
        drive();
        #1;
        asserts++;
        if ({busy_o, recoverDone_o, recoverErr_o} !== 3'b000) begin
            failures++;
            $display("FAIL midreset T+6: got busy/done/err %b expected 000", {busy_o, recoverDone_o, recoverErr_o});
        end
        step();
        asserts++;
        if ({busy_o, recoverDone_o} !== 2'b00) begin
            failures++;
            $display("FAIL midreset T+7: got busy/done %b expected 00", {busy_o, recoverDone_o});
        end
        for (int i = 0; i < NUM_LOG; i++) refTable[i] = i;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_random_rename();
        test_readback();
        test_recovery();
        test_readback();
        test_restart();
        test_readback();
        test_error();
        test_reset_mid();
        test_readback();
        test_random_rename();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
